// File: rtl/instruction_issue_unit.sv
// instruction_issue_unit
// Front-end fetch/issue stage. Owns the PC, reads 32-bit words from a
// synchronous instruction ROM (one cycle read latency), splits each word
// into the decode field set and presents it through a 2-entry issue buffer
// over a valid/ready handshake. A jump from execute flushes the buffer and
// any in-flight read and restarts fetch at the jump target.
//
// Optional feature, selected with the macro ILLEGAL_TRAP_EN:
//   defined   - a type 2'b11 word is issued normally; its transfer sets
//               halted, stops fetch and discards everything else. Only
//               reset leaves the halted state, and jumps are ignored.
//   undefined - a type 2'b11 word is dropped when it returns from the ROM
//               and halted is tied low.
module instruction_issue_unit #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              issue_ready,
    output logic              issue_valid,
    output logic [1:0]        instruction_type,
    output logic [1:0]        func,
    output logic              imm,
    output logic              vector,
    output logic [25:0]       operands,
    output logic [ADDR_W-1:0] issue_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};

    // Architectural state
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic              inflight_r;
    logic [1:0]        count_r;
    logic              rd_ptr_r;
    logic              wr_ptr_r;
    logic              halted_r;
    logic [DATA_W-1:0] buf_data_r [2];
    logic [ADDR_W-1:0] buf_pc_r   [2];

    // Per-cycle decisions
    logic              pop_s;
    logic              push_s;
    logic              fetch_s;
    logic              jump_s;
    logic              trap_s;
    logic [2:0]        occupancy_s;
    logic [DATA_W-1:0] head_word_s;

    // Handshake, fetch, push, jump and trap decisions for the current cycle
    always_comb begin
        pop_s       = 1'b0;
        push_s      = 1'b0;
        fetch_s     = 1'b0;
        jump_s      = 1'b0;
        trap_s      = 1'b0;
        head_word_s = buf_data_r[rd_ptr_r];

        if ((count_r != 2'd0) && issue_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end

        // The in-flight read already owns a buffer slot, so it is counted
        // here; this is what keeps a full buffer from being overrun.
        occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

        if (rst && !halted_r && !jump_en && (occupancy_s < 3'd2)) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end

        if (jump_en && !halted_r) begin
            jump_s = 1'b1;
        end else begin
            jump_s = 1'b0;
        end

`ifdef ILLEGAL_TRAP_EN
        if (inflight_r) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (pop_s && (head_word_s[31:30] == 2'b11)) begin
            trap_s = 1'b1;
        end else begin
            trap_s = 1'b0;
        end
`else
        if (inflight_r && (imem_rdata[31:30] != 2'b11)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        trap_s = 1'b0;
`endif
    end

    // PC, in-flight flag, issue buffer and halt state; trap beats jump beats
    // normal push/pop, and reset beats everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_r          <= PC_ZERO;
            inflight_pc_r <= PC_ZERO;
            inflight_r    <= 1'b0;
            count_r       <= 2'd0;
            rd_ptr_r      <= 1'b0;
            wr_ptr_r      <= 1'b0;
            halted_r      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= {DATA_W{1'b0}};
                buf_pc_r[i]   <= PC_ZERO;
            end
        end else if (trap_s) begin
            halted_r   <= 1'b1;
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
        end else if (jump_s) begin
            pc_r       <= jump_target;
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
        end else begin
            inflight_r <= fetch_s;
            if (fetch_s) begin
                pc_r          <= pc_r + PC_ONE;
                inflight_pc_r <= pc_r;
            end
            if (push_s) begin
                buf_data_r[wr_ptr_r] <= imem_rdata;
                buf_pc_r[wr_ptr_r]   <= inflight_pc_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    assign imem_en          = fetch_s;
    assign imem_addr        = fetch_s ? pc_r : PC_ZERO;
    assign issue_valid      = (count_r != 2'd0);
    assign instruction_type = head_word_s[31:30];
    assign func             = head_word_s[29:28];
    assign imm              = head_word_s[27];
    assign vector           = head_word_s[26];
    assign operands         = head_word_s[25:0];
    assign issue_pc         = buf_pc_r[rd_ptr_r];
`ifdef ILLEGAL_TRAP_EN
    assign halted           = halted_r;
`else
    assign halted           = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Self-checking bench for instruction_issue_unit: directed vector tables for
// latency, stall, jump, wrap, illegal-type and mid-run reset, then a random
// run scored against an in-order stream model of the program.
module tb_instruction_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        jump_en;
    logic [9:0]  jump_target;
    logic        issue_ready;
    logic        issue_valid;
    logic [1:0]  instruction_type;
    logic [1:0]  func;
    logic        imm;
    logic        vector;
    logic [25:0] operands;
    logic [9:0]  issue_pc;
    logic        halted;

    logic [31:0] rom [0:1023];
    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v_rst;
        logic       v_rdy;
        logic       v_jmp;
        logic [9:0] v_tgt;
        logic       e_en;
        logic [9:0] e_addr;
        logic       e_vld;
        logic [9:0] e_pc;
        logic       e_hlt;
        logic       e_zero;
    } vec_t;

    vec_t tbl[$];

    instruction_issue_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_en          (imem_en),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .jump_en          (jump_en),
        .jump_target      (jump_target),
        .issue_ready      (issue_ready),
        .issue_valid      (issue_valid),
        .instruction_type (instruction_type),
        .func             (func),
        .imm              (imm),
        .vector           (vector),
        .operands         (operands),
        .issue_pc         (issue_pc),
        .halted           (halted)
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM: data the cycle after the read strobe
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int rs, input int rd, input int jm, input int tg,
                       input int en, input int ad, input int vl, input int pc,
                       input int hl, input int zf);
        vec_t v;
        v.v_rst = rs[0]; v.v_rdy = rd[0]; v.v_jmp = jm[0]; v.v_tgt = tg[9:0];
        v.e_en = en[0]; v.e_addr = ad[9:0]; v.e_vld = vl[0]; v.e_pc = pc[9:0];
        v.e_hlt = hl[0]; v.e_zero = zf[0];
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b0; issue_ready = 1'b0; jump_en = 1'b0; jump_target = 10'h000;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic default_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 32'(i);
        rom[0] = 32'h0000_0000;
        rom[1] = 32'h5000_0000;
        rom[2] = 32'h8C00_0001;
        rom[3] = 32'h9800_0002;
    endtask

    // One row per cycle: drive after the rising edge, compare at the falling edge
    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            rst         = tbl[i].v_rst;
            issue_ready = tbl[i].v_rdy;
            jump_en     = tbl[i].v_jmp;
            jump_target = tbl[i].v_tgt;
            @(negedge clk);
            check($sformatf("%s[%0d].imem_en", tag, i), 32'(imem_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en || tbl[i].e_zero)
                check($sformatf("%s[%0d].imem_addr", tag, i), 32'(imem_addr), 32'(tbl[i].e_addr));
            check($sformatf("%s[%0d].issue_valid", tag, i), 32'(issue_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                check($sformatf("%s[%0d].issue_pc", tag, i), 32'(issue_pc), 32'(tbl[i].e_pc));
                check($sformatf("%s[%0d].fields", tag, i),
                      {instruction_type, func, imm, vector, operands}, rom[tbl[i].e_pc]);
            end
            if (tbl[i].e_zero) begin
                check($sformatf("%s[%0d].fields_zero", tag, i),
                      {instruction_type, func, imm, vector, operands}, 32'h0);
                check($sformatf("%s[%0d].issue_pc_zero", tag, i), 32'(issue_pc), 32'h0);
            end
            check($sformatf("%s[%0d].halted", tag, i), 32'(halted), 32'(tbl[i].e_hlt));
            @(posedge clk);
            #1;
        end
        tbl.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_pc;
        logic [9:0] e;
        logic [9:0] hold_pc;
        logic       hold_v;
        logic       jumped;
        int         gap;
        int         max_gap;
        int         xfers;

        rst = 1'b0; issue_ready = 1'b0; jump_en = 1'b0; jump_target = 10'h000;
        @(posedge clk);
        #1;

        // Latency and one-per-cycle throughput after reset
        default_rom();
        do_reset();
        //  rs rd jm tgt   en addr vl pc  hl zf
        add(0, 1, 0, 0,    0, 0,   0, 0,  0, 1);
        add(1, 1, 0, 0,    1, 0,   0, 0,  0, 1);
        add(1, 1, 0, 0,    1, 1,   0, 0,  0, 0);
        add(1, 1, 0, 0,    1, 2,   1, 0,  0, 0);
        add(1, 1, 0, 0,    1, 3,   1, 1,  0, 0);
        add(1, 1, 0, 0,    1, 4,   1, 2,  0, 0);
        add(1, 1, 0, 0,    1, 5,   1, 3,  0, 0);
        run_table("stream");

        // Decode stalls for 5 cycles: fetch stops at two owned slots, nothing lost
        do_reset();
        add(1, 0, 0, 0,    1, 0,   0, 0,  0, 1);
        add(1, 0, 0, 0,    1, 1,   0, 0,  0, 0);
        add(1, 0, 0, 0,    0, 0,   1, 0,  0, 0);
        add(1, 0, 0, 0,    0, 0,   1, 0,  0, 0);
        add(1, 0, 0, 0,    0, 0,   1, 0,  0, 0);
        add(1, 0, 0, 0,    0, 0,   1, 0,  0, 0);
        add(1, 0, 0, 0,    0, 0,   1, 0,  0, 0);
        add(1, 1, 0, 0,    1, 2,   1, 0,  0, 0);
        add(1, 1, 0, 0,    1, 3,   1, 1,  0, 0);
        add(1, 1, 0, 0,    1, 4,   1, 2,  0, 0);
        add(1, 1, 0, 0,    1, 5,   1, 3,  0, 0);
        run_table("stall");

        // Jump with two words buffered: flush, refetch at target
        do_reset();
        add(1, 0, 0, 0,      1, 0,     0, 0,     0, 1);
        add(1, 0, 0, 0,      1, 1,     0, 0,     0, 0);
        add(1, 0, 0, 0,      0, 0,     1, 0,     0, 0);
        add(1, 0, 0, 0,      0, 0,     1, 0,     0, 0);
        add(1, 0, 1, 'h100,  0, 0,     1, 0,     0, 0);
        add(1, 1, 0, 0,      1, 'h100, 0, 0,     0, 0);
        add(1, 1, 0, 0,      1, 'h101, 0, 0,     0, 0);
        add(1, 1, 0, 0,      1, 'h102, 1, 'h100, 0, 0);
        add(1, 1, 0, 0,      1, 'h103, 1, 'h101, 0, 0);
        run_table("jump");

        // PC wrap from the top of the address space
        do_reset();
        add(1, 1, 1, 'h3FE,  0, 0,     0, 0,     0, 0);
        add(1, 1, 0, 0,      1, 'h3FE, 0, 0,     0, 0);
        add(1, 1, 0, 0,      1, 'h3FF, 0, 0,     0, 0);
        add(1, 1, 0, 0,      1, 'h000, 1, 'h3FE, 0, 0);
        add(1, 1, 0, 0,      1, 'h001, 1, 'h3FF, 0, 0);
        add(1, 1, 0, 0,      1, 'h002, 1, 'h000, 0, 0);
        run_table("wrap");

        // Illegal instruction type at address 2
        rom[2] = 32'hC000_0000;
        do_reset();
        add(1, 1, 0, 0,    1, 0,   0, 0,  0, 1);
        add(1, 1, 0, 0,    1, 1,   0, 0,  0, 0);
        add(1, 1, 0, 0,    1, 2,   1, 0,  0, 0);
        add(1, 1, 0, 0,    1, 3,   1, 1,  0, 0);
`ifdef ILLEGAL_TRAP_EN
        add(1, 1, 0, 0,      1, 4,   1, 2,  0, 0);
        add(1, 1, 1, 'h100,  0, 0,   0, 0,  1, 0);
        add(1, 1, 0, 0,      0, 0,   0, 0,  1, 0);
        add(1, 1, 0, 0,      0, 0,   0, 0,  1, 0);
`else
        add(1, 1, 0, 0,    1, 4,   0, 0,  0, 0);
        add(1, 1, 0, 0,    1, 5,   1, 3,  0, 0);
        add(1, 1, 0, 0,    1, 6,   1, 4,  0, 0);
`endif
        run_table("illegal");
        default_rom();

        // Reset for one edge with a word buffered and a read in flight
        do_reset();
        add(1, 0, 0, 0,    1, 0,   0, 0,  0, 1);
        add(1, 0, 0, 0,    1, 1,   0, 0,  0, 0);
        add(0, 0, 0, 0,    0, 0,   1, 0,  0, 0);
        add(1, 0, 0, 0,    1, 0,   0, 0,  0, 1);
        add(1, 0, 0, 0,    1, 1,   0, 0,  0, 0);
        add(1, 1, 0, 0,    1, 2,   1, 0,  0, 0);
        run_table("midreset");

        // Random run: every transferred word must be the next word of the
        // program stream, restarted at each jump target
        for (int i = 0; i < 1024; i++) begin
            rom[i] = $urandom;
`ifdef ILLEGAL_TRAP_EN
            if (rom[i][31:30] == 2'b11) rom[i][31] = 1'b0;
`endif
        end
        do_reset();
        rst = 1'b1;
        exp_pc = 10'h000; hold_v = 1'b0; hold_pc = 10'h000; jumped = 1'b0;
        gap = 0; max_gap = 0; xfers = 0;
        for (int c = 0; c < 4000; c++) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            jump_en     = ($urandom_range(0, 39) == 0);
            jump_target = 10'($urandom);
            @(negedge clk);
            if (jumped) begin
                check("rnd.valid_after_jump", 32'(issue_valid), 32'h0);
            end else if (hold_v) begin
                check("rnd.hold_valid", 32'(issue_valid), 32'h1);
                check("rnd.hold_pc", 32'(issue_pc), 32'(hold_pc));
            end
            if (issue_valid && issue_ready) begin
                e = exp_pc;
`ifndef ILLEGAL_TRAP_EN
                for (int k = 0; k < 1024 && rom[e][31:30] == 2'b11; k++) e = e + 10'd1;
`endif
                check("rnd.issue_pc", 32'(issue_pc), 32'(e));
                check("rnd.fields", {instruction_type, func, imm, vector, operands}, rom[e]);
                exp_pc = e + 10'd1;
                xfers++;
                gap = 0;
            end else begin
                gap++;
            end
            hold_v  = issue_valid && !issue_ready && !jump_en;
            hold_pc = issue_pc;
            if (jump_en) begin
                exp_pc = jump_target;
                gap    = 0;
            end
            jumped = jump_en;
            if (gap > max_gap) max_gap = gap;
            @(posedge clk);
            #1;
        end
        jump_en = 1'b0;
        check("rnd.max_gap_le_64", 32'(max_gap <= 64), 32'h1);
        check("rnd.progress_ge_1000", 32'(xfers >= 1000), 32'h1);
        check("rnd.halted", 32'(halted), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
